// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway
// Controller FSM for an N-way set-associative cache with tree pseudo-LRU
// replacement. It sits between the arbiter request port and physical memory,
// and drives the way arrays, the LRU array and the datapath muxes.
//
// Optional feature macro: CACHE_VICTIM_EN
//   defined   : valid clean victims pass through a one-cycle EVICT state
//               (eviction = 1) so that a victim cache can capture the line.
//   undefined : clean victims go straight to FETCH.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   mem_read, mem_write           arbiter request (valid when exactly one high)
//   mem_resp                      request complete (combinational, hit cycle)
//   way_hit/way_valid/way_dirty   per-way tag compare and status of the set
//   lru_in / lru_out / load_lru   PLRU tree bits in, updated bits, write enable
//   load_tag/load_v/load_d        per-way array write enables
//   v_in / d_in                   per-way valid / dirty write data
//   data_sel                      way select for data mux
//   addr_sel                      0 = request address, k+1 = tag of way k
//   pmem_read/pmem_write/pmem_resp physical memory handshake
//   eviction                      victim line is on the datapath
//   clr_cnt                       synchronous counter clear
//   hit_cnt/miss_cnt/wb_cnt       saturating performance counters
module cache_ctrl_nway #(
    parameter int WAYS  = 8,
    parameter int CNT_W = 16,
    localparam int WSEL_W = $clog2(WAYS),
    localparam int ASEL_W = WSEL_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_resp,
    input  logic [WAYS-1:0]   way_hit,
    input  logic [WAYS-1:0]   way_valid,
    input  logic [WAYS-1:0]   way_dirty,
    input  logic [WAYS-2:0]   lru_in,
    output logic [WAYS-2:0]   lru_out,
    output logic              load_lru,
    output logic [WAYS-1:0]   load_tag,
    output logic [WAYS-1:0]   load_v,
    output logic [WAYS-1:0]   load_d,
    output logic [WAYS-1:0]   v_in,
    output logic [WAYS-1:0]   d_in,
    output logic [WSEL_W-1:0] data_sel,
    output logic [ASEL_W-1:0] addr_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp,
    output logic              eviction,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] BUFFER     = 3'd1;
    localparam logic [2:0] WRITE_BACK = 3'd2;
`ifdef CACHE_VICTIM_EN
    localparam logic [2:0] EVICT      = 3'd3;
`endif
    localparam logic [2:0] FETCH      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [WSEL_W-1:0] victim_q, victim_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]  wb_cnt_q, wb_cnt_d;
    logic              hit_inc, miss_inc, wb_inc;
    logic [WSEL_W-1:0] hit_way;
    logic [WSEL_W-1:0] plru_way;

    // Walk the tree from the root following the stored bits; the address bits
    // of the victim are collected MSB first (root decides the MSB).
    function automatic logic [WSEL_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WSEL_W-1:0] v;
        logic              b;
        int                node;
        v    = '0;
        node = 0;
        for (int d = 0; d < WSEL_W; d++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) b = bits[n];
            end
            v    = (v << 1) | WSEL_W'(b);
            node = 2 * node + 1 + int'(b);
        end
        return v;
    endfunction

    // Every node on the accessed way's path is turned to point away from it.
    function automatic logic [WAYS-2:0] plru_access(input logic [WAYS-2:0] bits,
                                                     input logic [WSEL_W-1:0] way);
        logic [WAYS-2:0]   r;
        logic [WSEL_W-1:0] t;
        logic              b;
        int                node;
        r    = bits;
        t    = way;
        node = 0;
        for (int d = 0; d < WSEL_W; d++) begin
            b = t[WSEL_W-1];
            t = t << 1;
            for (int n = 0; n < WAYS - 1; n++) begin
                if (n == node) r[n] = ~b;
            end
            node = 2 * node + 1 + int'(b);
        end
        return r;
    endfunction

    // Lowest-index hitting way wins if several tags compare equal.
    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (way_hit[i]) hit_way = WSEL_W'(i);
        end
    end

    assign plru_way = plru_victim(lru_in);

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        mem_resp   = 1'b0;
        lru_out    = lru_in;
        load_lru   = 1'b0;
        load_tag   = '0;
        load_v     = '0;
        load_d     = '0;
        v_in       = '0;
        d_in       = '0;
        data_sel   = '0;
        addr_sel   = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        eviction   = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    if (|way_hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_out  = plru_access(lru_in, hit_way);
                        data_sel = hit_way;
                        hit_inc  = 1'b1;
                        if (mem_write) begin
                            d_in[hit_way]     = 1'b1;
                            load_d[hit_way]   = 1'b1;
                            load_tag[hit_way] = 1'b1;
                        end
                        state_d = BUFFER;
                    end else begin
                        // The victim is frozen here so later lru_in changes
                        // cannot redirect the refill.
                        victim_d = plru_way;
                        data_sel = plru_way;
                        addr_sel = {1'b0, plru_way} + ASEL_W'(1);
                        miss_inc = 1'b1;
                        if (way_valid[plru_way] && way_dirty[plru_way]) begin
                            state_d = WRITE_BACK;
                            wb_inc  = 1'b1;
                        end
`ifdef CACHE_VICTIM_EN
                        else if (way_valid[plru_way]) begin
                            state_d = EVICT;
                        end
`endif
                        else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            BUFFER: begin
                state_d = IDLE;
            end
            WRITE_BACK: begin
                pmem_write = 1'b1;
                eviction   = 1'b1;
                data_sel   = victim_q;
                // Address switches to the request as the writeback completes.
                if (pmem_resp) begin
                    addr_sel = '0;
                    state_d  = FETCH;
                end else begin
                    addr_sel = {1'b0, victim_q} + ASEL_W'(1);
                end
            end
`ifdef CACHE_VICTIM_EN
            EVICT: begin
                eviction = 1'b1;
                data_sel = victim_q;
                addr_sel = '0;
                state_d  = FETCH;
            end
`endif
            FETCH: begin
                pmem_read          = 1'b1;
                addr_sel           = '0;
                load_tag[victim_q] = 1'b1;
                load_v[victim_q]   = 1'b1;
                load_d[victim_q]   = 1'b1;
                v_in[victim_q]     = 1'b1;
                if (pmem_resp) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating counters; a clear overrides any increment in the same cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (clr_cnt) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            wb_cnt_d   = '0;
        end else begin
            if (hit_inc && (hit_cnt_q != '1))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
            if (wb_inc && (wb_cnt_q != '1))     wb_cnt_d   = wb_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised N-way set-associative cache controller FSM: a generalised successor to the fixed 8-way L2 controller. Sits between the arbiter-side request port and physical memory, and drives the way arrays, LRU array and datapath muxes. Adds configurable way count, a generic tree-PLRU, a latched victim, and saturating hit/miss/writeback counters. The victim-cache eviction handshake is optional.

## Interface
Parameters:
- `WAYS`, 8: associativity; power of two, 2..16.
- `CNT_W`, 16: width of each performance counter.
- Derived `WSEL_W` = $clog2(WAYS); `ASEL_W` = WSEL_W+1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `mem_read`, `mem_write`  in  1 each  arbiter request; valid only when exactly one is high.
- `mem_resp`  out  1  request complete (hit cycle).
- `way_hit`, `way_valid`, `way_dirty`  in  WAYS each  per-way tag-compare and status bits for the indexed set.
- `lru_in`  in  WAYS-1  PLRU tree bits of the indexed set.
- `lru_out`  out  WAYS-1  updated PLRU bits.
- `load_lru`  out  1  LRU array write enable.
- `load_tag`, `load_v`, `load_d`, `v_in`, `d_in`  out  WAYS each  per-way array controls.
- `data_sel`  out  WSEL_W  way select for the read / writeback data mux.
- `addr_sel`  out  ASEL_W  pmem address mux: 0 = request address, k+1 = stored tag of way k.
- `pmem_read`, `pmem_write`  out  1 each.  `pmem_resp`  in  1.
- `eviction`  out  1  victim line is on the datapath (writeback or victim-cache transfer).
- `clr_cnt`  in  1  synchronous counter clear.
- `hit_cnt`, `miss_cnt`, `wb_cnt`  out  CNT_W each.

## Operation
PLRU tree:
- Node 0 is the root; node i has children 2i+1 and 2i+2; leaves are the ways, in index order.
- Bit value 0 means the victim is in the left subtree; 1 means the right subtree.
- Victim = leaf reached by following the bits from the root.
- Access to way w: every node on w's path is set to point away from w (bit := NOT of w's address bit at that depth). All other bits are unchanged.

States: IDLE, BUFFER, WRITE_BACK, EVICT, FETCH.
- IDLE, valid request (mem_read XOR mem_write):
  - Hit: hit way h = lowest index with way_hit set. Assert mem_resp, load_lru, lru_out = access(h), data_sel = h.
  - Write hit: additionally d_in[h] = load_d[h] = load_tag[h] = 1.
  - Next state after a hit: BUFFER.
  - Miss: latch the victim in victim_q. Dirty victim → WRITE_BACK. Valid, clean victim → EVICT (only if the macro is defined). Otherwise → FETCH.
  - Miss cycle: data_sel = victim, addr_sel = victim+1.
- IDLE, no request or both request lines high: no outputs, stay in IDLE.
- BUFFER: one idle cycle, then IDLE.
- WRITE_BACK: pmem_write = 1, eviction = 1, data_sel = victim_q, addr_sel = victim_q+1.
  - On pmem_resp: addr_sel = 0, next state FETCH.
- EVICT: eviction = 1, addr_sel = 0 for one cycle, then FETCH.
- FETCH: pmem_read = 1, addr_sel = 0. Every cycle: load_tag/load_v/load_d[victim_q] = 1, v_in = 1, d_in = 0.
  - On pmem_resp: next state IDLE; the replayed request then hits.
- Default outputs: all 0, except lru_out = lru_in.
- Counters:
  - hit_cnt increments on an IDLE hit decision.
  - miss_cnt increments on an IDLE miss decision.
  - wb_cnt increments on entry to WRITE_BACK.
  - All counters saturate at all-ones.
  - clr_cnt zeroes all counters and wins over a simultaneous increment.

## Timing
- Hit: mem_resp is combinational in the hit cycle. Back-to-back hits are at most one every 2 cycles (because of BUFFER).
- Clean miss, no victim cache: 1 IDLE cycle + FETCH cycles up to and including pmem_resp, then a hit 1 cycle later.
- Victim is frozen in victim_q from the miss cycle onward. lru_in changes during a miss are ignored until the return to IDLE.
- pmem_read and pmem_write are held steady until pmem_resp. They are never asserted together.
- Reset, including mid-transaction:
  - Next edge: state = IDLE, victim_q = 0, counters = 0.
  - All outputs go to their default values.
  - An in-flight pmem transaction is abandoned.

## Configuration
- `CACHE_VICTIM_EN` defined: EVICT state exists; valid clean victims pass through EVICT for one cycle with eviction = 1.
- `CACHE_VICTIM_EN` undefined: EVICT is not built; clean victims go straight to FETCH; eviction is asserted only in WRITE_BACK.

## Test plan
- WAYS=8, lru_in=7'b0000000, read hit way 5 → mem_resp=1, load_lru=1, lru_out=7'b0000100, data_sel=5, then one BUFFER cycle, then IDLE.
- WAYS=8, lru_in=0, write miss with way 0 valid and dirty → WRITE_BACK with addr_sel=1, pmem_write held 3 cycles until pmem_resp → FETCH, pmem_read, load_v[0]=1, d_in=0 → IDLE; wb_cnt=1, miss_cnt=1.
- Clean valid victim → EVICT for exactly 1 cycle with eviction=1 when `CACHE_VICTIM_EN` is defined; direct FETCH when it is undefined.
- mem_read=mem_write=1 with way_hit=8'h01 → no mem_resp, no counter change.
- way_hit=8'b0010_0100 → hit way 2 selected; lru_in changed during FETCH → load_* target victim_q unchanged.
- CNT_W=2: 5 hits → hit_cnt=3; clr_cnt asserted coincident with a hit → 0; rst_n low during FETCH → IDLE next edge, pmem_read=0.
